// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared DMI constants, FSM state type and status helper
//
// Purpose: common definitions for the core-clock DMI bridge.
// Contents: DMI field widths, DMI op status codes, bridge FSM state enum,
//           escalate() which merges a new status into the sticky status.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  localparam logic [1:0] OP_SUCCESS = 2'd0;
  localparam logic [1:0] OP_FAILED  = 2'd2;
  localparam logic [1:0] OP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } dmi_state_e;

  // The op codes are ordered by severity (0 < 2 < 3), so the sticky status
  // escalates by taking the larger code and never moves back down.
  function automatic logic [1:0] escalate(input logic [1:0] cur, input logic [1:0] op);
    return (op > cur) ? op : cur;
  endfunction

endpackage

// File: rtl/rvsync_pulse.sv
// rtl/rvsync_pulse.sv - level synchronizer with rising-edge strobe output
//
// Purpose: brings an asynchronous level into the i_clk domain through a
//          STAGES-deep flop chain and emits a one-cycle strobe on its rise.
// Ports:
//   i_clk    in  1  destination clock
//   i_rst_n  in  1  synchronous active-low reset
//   i_level  in  1  asynchronous level
//   o_pulse  out 1  one-cycle strobe on the synchronized rising edge
module rvsync_pulse #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_level};
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Decoded from flops only, so the strobe is glitch-free for the consumer.
  assign o_pulse = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/dmi_core_bridge.sv
// rtl/dmi_core_bridge.sv - TAP-to-Debug-Module request bridge in the core clock
//
// Purpose: synchronizes TAP DMI strobes, issues single-beat Debug Module
//          requests, captures read responses and reports DMI op status.
// Ports:
//   clock, reset                      core clock, synchronous active-low reset
//   io_wr_en/io_rd_en                 TAP request levels (async)
//   io_wr_addr/io_wr_data             quasi-static request address/data
//   io_dmi_reset/io_dmi_hard_reset    async status clear / transaction abort
//   io_rd_data/io_rd_status           last read data, op status incl. busy
//   io_dmi_stat                       sticky status only
//   io_dmi_req_*                      request channel to Debug Module
//   io_dmi_resp_*                     response channel from Debug Module
module dmi_core_bridge
  import dmi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_wr_en,
  input  logic                  io_rd_en,
  input  logic [DMI_ADDR_W-1:0] io_wr_addr,
  input  logic [DMI_DATA_W-1:0] io_wr_data,
  input  logic                  io_dmi_reset,
  input  logic                  io_dmi_hard_reset,
  output logic [DMI_DATA_W-1:0] io_rd_data,
  output logic [1:0]            io_rd_status,
  output logic [1:0]            io_dmi_stat,
  output logic                  io_dmi_req_valid,
  input  logic                  io_dmi_req_ready,
  output logic                  io_dmi_req_write,
  output logic [DMI_ADDR_W-1:0] io_dmi_req_addr,
  output logic [DMI_DATA_W-1:0] io_dmi_req_data,
  input  logic                  io_dmi_resp_valid,
  input  logic [DMI_DATA_W-1:0] io_dmi_resp_data,
  input  logic                  io_dmi_resp_err
);

  localparam logic [7:0] LP_TIMEOUT = 8'(RESP_TIMEOUT);

  logic w_en_level;
  logic w_en_pulse;
  logic w_clr_pulse;
  logic w_hard_pulse;

  assign w_en_level = io_wr_en | io_rd_en;

  rvsync_pulse #(.STAGES(SYNC_STAGES)) u_sync_en (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_level (w_en_level),
    .o_pulse (w_en_pulse)
  );

  rvsync_pulse #(.STAGES(SYNC_STAGES)) u_sync_clr (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_level (io_dmi_reset),
    .o_pulse (w_clr_pulse)
  );

  rvsync_pulse #(.STAGES(SYNC_STAGES)) u_sync_hard (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_level (io_dmi_hard_reset),
    .o_pulse (w_hard_pulse)
  );

  // io_wr_en gets its own chain of the same depth so its synchronized value
  // lines up with the en strobe and selects write vs read.
  logic [SYNC_STAGES-1:0] r_wr_sync;

  dmi_state_e            r_state,     w_state_nx;
  logic [1:0]            r_sticky,    w_sticky_nx;
  logic [7:0]            r_cnt,       w_cnt_nx;
  logic [DMI_DATA_W-1:0] r_rd_data,   w_rd_data_nx;
  logic [1:0]            r_rd_status, w_rd_status_nx;
  logic                  r_req_valid, w_req_valid_nx;
  logic                  r_req_write, w_req_write_nx;
  logic [DMI_ADDR_W-1:0] r_req_addr,  w_req_addr_nx;
  logic [DMI_DATA_W-1:0] r_req_data,  w_req_data_nx;
  logic [7:0]            w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_nx     = r_state;
    w_sticky_nx    = r_sticky;
    w_cnt_nx       = r_cnt;
    w_rd_data_nx   = r_rd_data;
    w_req_valid_nx = r_req_valid;
    w_req_write_nx = r_req_write;
    w_req_addr_nx  = r_req_addr;
    w_req_data_nx  = r_req_data;

    case (r_state)
      ST_IDLE: begin
        // A pending error blocks new requests; a same-cycle clear also drops it.
        if (w_en_pulse && (r_sticky == OP_SUCCESS) && !w_clr_pulse) begin
          w_req_addr_nx  = io_wr_addr;
          w_req_data_nx  = io_wr_data;
          w_req_write_nx = r_wr_sync[SYNC_STAGES-1];
          w_req_valid_nx = 1'b1;
          w_state_nx     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (io_dmi_req_ready) begin
          w_req_valid_nx = 1'b0;
          w_cnt_nx       = 8'd0;
          w_state_nx     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (io_dmi_resp_valid) begin
          w_state_nx = ST_IDLE;
          if (io_dmi_resp_err) begin
            w_sticky_nx = escalate(w_sticky_nx, OP_FAILED);
          end else if (!r_req_write) begin
            w_rd_data_nx = io_dmi_resp_data;
          end
        end else if (w_cnt_inc == LP_TIMEOUT) begin
          w_state_nx  = ST_IDLE;
          w_cnt_nx    = 8'd0;
          w_sticky_nx = escalate(w_sticky_nx, OP_FAILED);
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Overrun: the TAP asked again before the previous access finished.
    if (w_en_pulse && (r_state != ST_IDLE)) begin
      w_sticky_nx = escalate(w_sticky_nx, OP_BUSY);
    end

    if (w_clr_pulse) begin
      w_sticky_nx = OP_SUCCESS;
    end

    if (w_hard_pulse) begin
      w_state_nx     = ST_IDLE;
      w_req_valid_nx = 1'b0;
      w_sticky_nx    = OP_SUCCESS;
      w_cnt_nx       = 8'd0;
    end

    // Status is computed from next-state values so the output stays registered.
    w_rd_status_nx = (w_state_nx != ST_IDLE) ? OP_BUSY : w_sticky_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_sync   <= '0;
      r_state     <= ST_IDLE;
      r_sticky    <= OP_SUCCESS;
      r_cnt       <= 8'd0;
      r_rd_data   <= '0;
      r_rd_status <= OP_SUCCESS;
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
    end else begin
      r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], io_wr_en};
      r_state     <= w_state_nx;
      r_sticky    <= w_sticky_nx;
      r_cnt       <= w_cnt_nx;
      r_rd_data   <= w_rd_data_nx;
      r_rd_status <= w_rd_status_nx;
      r_req_valid <= w_req_valid_nx;
      r_req_write <= w_req_write_nx;
      r_req_addr  <= w_req_addr_nx;
      r_req_data  <= w_req_data_nx;
    end
  end

  assign io_rd_data       = r_rd_data;
  assign io_rd_status     = r_rd_status;
  assign io_dmi_stat      = r_sticky;
  assign io_dmi_req_valid = r_req_valid;
  assign io_dmi_req_write = r_req_write;
  assign io_dmi_req_addr  = r_req_addr;
  assign io_dmi_req_data  = r_req_data;

endmodule
